mul_issue_ctrl: RTL

// Execute-stage front end for the iterative multiplier. Accepts an M-ext multiply from the E stage and

---
 rtl/mext_pkg.sv | 21 ++
 rtl/mul_issue_ctrl_if.sv | 42 ++++
 rtl/mul_watchdog_cnt.sv | 37 +++
 rtl/mul_issue_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mext_pkg.sv
// Shared M-extension types for the execute-stage multiplier front end.
package mext_pkg;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    MUL,
    MULH,
    MULHSU,
    MULHU
  } mul_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } mul_issue_state_e;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// E-stage request, multiplier and writeback signals of the multiply issue controller.
interface mul_issue_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic [1:0]      req_funct3;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [4:0]      req_rd;
  logic            flush;
  logic            stall_o;
  logic            startE;
  logic [1:0]      mul_opcode;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            mul_done;
  logic            mul_use;
  logic [XLEN-1:0] mul_result;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            mul_err;

  modport master (
    input  req_valid, req_funct3, req_rs1, req_rs2,
    input  req_rd, flush,
    input  mul_done, mul_use, mul_result,
    output stall_o, startE, mul_opcode,
    output operand1, operand2,
    output wb_valid, wb_rd, wb_data, mul_err
  );

  modport slave (
    output req_valid, req_funct3, req_rs1, req_rs2,
    output req_rd, flush,
    output mul_done, mul_use, mul_result,
    input  stall_o, startE, mul_opcode,
    input  operand1, operand2,
    input  wb_valid, wb_rd, wb_data, mul_err
  );

endinterface

// File: rtl/mul_watchdog_cnt.sv
// Cycle watchdog: cleared on state entry, counts while enabled,
// flags expiry on the LIMIT-th enabled cycle.
module mul_watchdog_cnt #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = enable && (cnt_q == W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Execute-stage front end for the iterative multiplier: stall,
// launch, wait for done, one-cycle writeback, flush and watchdog.
module mul_issue_ctrl
  import mext_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter bit EARLY_OUT   = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  mul_issue_ctrl_if.master bus
);

  mul_issue_state_e state_q, state_d;
  mul_op_e          op_q, op_d;
  logic [XLEN-1:0]  op1_q, op1_d;
  logic [XLEN-1:0]  op2_q, op2_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             start_q, start_d;
  logic             wb_valid_q, wb_valid_d;
  logic             err_q, err_d;
  logic             stall;
  logic             wd_clr;
  logic             wd_en;
  logic             wd_expired;
  logic             zero_opnd;

  assign zero_opnd = (bus.req_rs1 == '0) || (bus.req_rs2 == '0);
  assign wd_en     = (state_q == S_WAIT) || (state_q == S_DRAIN);

  mul_watchdog_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clr),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    start_d    = 1'b0;
    wb_valid_d = 1'b0;
    err_d      = 1'b0;
    stall      = 1'b0;
    wd_clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          stall   = 1'b1;
          op_d    = mul_op_e'(bus.req_funct3);
          op1_d   = bus.req_rs1;
          op2_d   = bus.req_rs2;
          wb_rd_d = bus.req_rd;
          if (EARLY_OUT && zero_opnd) begin
            wb_data_d  = '0;
            wb_valid_d = 1'b1;
            state_d    = S_RESP;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (!bus.mul_use) begin
          start_d = 1'b1;
          wd_clr  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus.flush) begin
          wd_clr  = 1'b1;
          state_d = S_DRAIN;
        end else if (bus.mul_done) begin
          wb_data_d  = bus.mul_result;
          wb_valid_d = 1'b1;
          state_d    = S_RESP;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        // the launched op is still in flight; hold any new instruction
        stall = bus.req_valid;
        if (bus.mul_done) begin
          state_d = S_IDLE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= MUL;
      op1_q      <= '0;
      op2_q      <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      start_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      start_q    <= start_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.stall_o    = stall && rst_n;
  assign bus.startE     = start_q;
  assign bus.mul_opcode = op_q;
  assign bus.operand1   = op1_q;
  assign bus.operand2   = op2_q;
  assign bus.wb_valid   = wb_valid_q && !bus.flush;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.mul_err    = err_q;

endmodule
